if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have stall_i  input  1  downstream decode stage not accepting; IF/ID register holds.
REQ-005 SHALL have flush_i  input  1  redirect request; discard fetched and pending work.
REQ-006 SHALL have new_pc_i  input  32  redirect target, sampled when flush_i=1.
REQ-007 SHALL have imem_ce_o  output  1  instruction memory request.
REQ-008 SHALL have imem_addr_o  output  32  fetch address, equal to internal pc.
REQ-009 SHALL have imem_ack_i  input  1  instruction valid this cycle, meaningful only while imem_ce_o=1.
REQ-010 SHALL have imem_rdata_i  input  32  returned instruction.
REQ-011 SHALL have id_pc_o  output  32  registered pc of instruction presented to decode.
REQ-012 SHALL have id_inst_o  output  32  registered instruction to decode; 32'h0 is a NOP bubble.

Function
REQ-013 SHALL implement states IDLE, FETCH, HOLD (HOLD only when IF_FETCH_BUF_EN defined).
REQ-014 SHALL drive imem_ce_o=1 in FETCH only; 0 in IDLE and HOLD.
REQ-015 SHALL move IDLE->FETCH unconditionally on the first clock after reset release.
REQ-016 SHALL, in FETCH with ack=1, stall=0, flush=0: load id_pc_o<=pc, id_inst_o<=imem_rdata_i, pc<=pc+4, stay FETCH.
REQ-017 SHALL, in FETCH with ack=0, stall=0, flush=0: load id_inst_o<=32'h0, hold id_pc_o and pc (bubble, request stays asserted at same address).
REQ-018 SHALL, whenever stall_i=1 and flush_i=0, hold id_pc_o and id_inst_o unchanged.
REQ-019 SHALL, on flush_i=1 in any state: pc<=new_pc_i, id_pc_o<=32'h0, id_inst_o<=32'h0, drop any same-cycle ack data and any buffered instruction, next state FETCH.
REQ-020 SHALL give priority flush > stall > ack.
REQ-021 SHALL compute pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-022 SHALL never change imem_addr_o while imem_ce_o=1 and ack not yet received, except on flush.
REQ-023 SHALL produce first instruction at id_inst_o no earlier than 2 cycles after rst deasserts (one-cycle-ack memory).

Reset
REQ-024 SHALL, while rst=1: state IDLE, pc<=RESET_PC, id_pc_o<=32'h0, id_inst_o<=32'h0, imem_ce_o=0, buffer empty.
REQ-025 SHALL let rst override flush_i, stall_i and imem_ack_i, including mid-transaction; pending ack is discarded.

Configuration
REQ-026 SHALL support macro IF_FETCH_BUF_EN enabling a one-entry instruction buffer.
REQ-027 SHALL, with IF_FETCH_BUF_EN, on FETCH ack=1 stall=1: capture rdata and pc into buffer, pc<=pc+4, go HOLD.
REQ-028 SHALL, with IF_FETCH_BUF_EN, in HOLD with stall=0: load IF/ID from buffer, empty buffer, go FETCH; stay HOLD while stall=1.
REQ-029 SHALL, without IF_FETCH_BUF_EN, on FETCH ack=1 stall=1: discard rdata, keep pc, stay FETCH (refetch same address).

Verification
REQ-030 SHALL cover reset release, ack=1 every cycle, rdata=pc-indexed words -> id_pc_o sequence 0x0,0x4,0x8 with matching id_inst_o, imem_ce_o=0 first cycle.
REQ-031 SHALL cover ack low 3 cycles at pc=0x8 -> three id_inst_o=0x0 bubbles, imem_addr_o stable 0x8, then inst@0x8.
REQ-032 SHALL cover flush_i=1 with new_pc_i=0x100 and ack=1 same cycle -> id_inst_o=0x0, next imem_addr_o=0x100, ack data dropped.
REQ-033 SHALL cover stall_i=1 for 2 cycles during ack at 0xC -> with macro: imem_ce_o=0, inst@0xC presented after stall release, then fetch 0x10; without: addr stays 0xC and refetches.
REQ-034 SHALL cover pc=32'hFFFF_FFFC ack -> next imem_addr_o=32'h0; and rst=1 mid-stall in HOLD -> all outputs zero, pc=RESET_PC.

Source files
------------

// File: rtl/if_fetch_if.sv
// if_fetch_if: handshake/bus bundle for the instruction fetch stage.
//   stall_i       decode not accepting; IF/ID register holds
//   flush_i       redirect request, target in new_pc_i
//   new_pc_i      redirect target
//   imem_ce_o     instruction memory request
//   imem_addr_o   fetch address (internal pc)
//   imem_ack_i    instruction valid this cycle while imem_ce_o=1
//   imem_rdata_i  returned instruction word
//   id_pc_o       registered pc presented to decode
//   id_inst_o     registered instruction presented to decode (0 = bubble)
// Modports: master = fetch stage, slave = pipeline control + memory side.
interface if_fetch_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        imem_ce_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  modport master (
    input  stall_i, flush_i, new_pc_i, imem_ack_i, imem_rdata_i,
    output imem_ce_o, imem_addr_o, id_pc_o, id_inst_o
  );

  modport slave (
    output stall_i, flush_i, new_pc_i, imem_ack_i, imem_rdata_i,
    input  imem_ce_o, imem_addr_o, id_pc_o, id_inst_o
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with IF/ID pipeline register.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   bus       if_fetch_if.master (stall/flush/redirect in, imem request/
//             response, IF/ID outputs)
// Parameter:
//   RESET_PC  first fetch address after reset
// Build option:
//   IF_FETCH_BUF_EN  adds a one-entry instruction buffer so an ack that
//                    arrives during a stall is kept instead of refetched.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in/just out of reset, no request
// FETCH | request asserted at pc, waiting for ack
// HOLD  | buffer holds an instruction, waiting for stall to drop
//       | (only with IF_FETCH_BUF_EN)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

`ifdef IF_FETCH_BUF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] pc_inc;

`ifdef IF_FETCH_BUF_EN
  logic        buf_vld_q, buf_vld_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
`endif

  // 32-bit add wraps naturally, so 0xFFFF_FFFC steps to 0x0.
  assign pc_inc = pc_q + 32'd4;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      id_pc_q   <= 32'h0;
      id_inst_q <= 32'h0;
`ifdef IF_FETCH_BUF_EN
      buf_vld_q  <= 1'b0;
      buf_pc_q   <= 32'h0;
      buf_inst_q <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
`ifdef IF_FETCH_BUF_EN
      buf_vld_q  <= buf_vld_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
`endif
    end
  end

  // Next-state and datapath logic; priority is flush > stall > ack.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
`ifdef IF_FETCH_BUF_EN
    buf_vld_d  = buf_vld_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
`endif

    if (bus.flush_i) begin
      // Redirect: drop same-cycle ack data and any buffered word.
      state_d   = FETCH;
      pc_d      = bus.new_pc_i;
      id_pc_d   = 32'h0;
      id_inst_d = 32'h0;
`ifdef IF_FETCH_BUF_EN
      buf_vld_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (bus.stall_i) begin
`ifdef IF_FETCH_BUF_EN
            if (bus.imem_ack_i) begin
              buf_vld_d  = 1'b1;
              buf_pc_d   = pc_q;
              buf_inst_d = bus.imem_rdata_i;
              pc_d       = pc_inc;
              state_d    = HOLD;
            end
`endif
            // Without the buffer an ack under stall is dropped and the
            // same address is requested again.
          end else if (bus.imem_ack_i) begin
            id_pc_d   = pc_q;
            id_inst_d = bus.imem_rdata_i;
            pc_d      = pc_inc;
          end else begin
            id_inst_d = 32'h0;
          end
        end
`ifdef IF_FETCH_BUF_EN
        HOLD: begin
          if (!bus.stall_i) begin
            id_pc_d   = buf_pc_q;
            id_inst_d = buf_inst_q;
            buf_vld_d = 1'b0;
            state_d   = FETCH;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.imem_ce_o   = (state_q == FETCH);
    bus.imem_addr_o = pc_q;
    bus.id_pc_o     = id_pc_q;
    bus.id_inst_o   = id_inst_q;
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: word at an address is a fixed, nonzero function of it.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a + 32'h1357_0001;
  endfunction

  assign bus.imem_rdata_i = word_at(bus.imem_addr_o);

  typedef struct packed {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
  } obs_t;

  typedef struct {
    logic        rs, st, fl, ak;
    logic [31:0] np;
    obs_t        e;
  } step_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic step_t mk(input logic rs, st, fl, ak, input logic [31:0] np,
                               input logic ce, input logic [31:0] addr, pc, inst);
    step_t s;
    s.rs = rs; s.st = st; s.fl = fl; s.ak = ak; s.np = np;
    s.e.ce = ce; s.e.addr = addr; s.e.pc = pc; s.e.inst = inst;
    return s;
  endfunction

  // Apply one step's inputs, queue its expected outcome, advance one edge.
  task automatic drive(input step_t s);
    rst            = s.rs;
    bus.stall_i    = s.st;
    bus.flush_i    = s.fl;
    bus.new_pc_i   = s.np;
    bus.imem_ack_i = s.ak;
    exp_q.push_back(s.e);
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.ce = bus.imem_ce_o; o.addr = bus.imem_addr_o;
    o.pc = bus.id_pc_o;   o.inst = bus.id_inst_o;
    return o;
  endfunction

  task automatic test_reset();
    step_t s[$];
    obs_t g, e;
    s.push_back(mk(1, 0, 0, 1, 32'h0, 0, RST_PC, 0, 0));
    s.push_back(mk(1, 1, 1, 1, 32'h40, 0, RST_PC, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 32'h0, 0, RST_PC, 0, 0));
    // First cycle after release: IDLE, ack ignored, then FETCH.
    s.push_back(mk(0, 0, 0, 1, 32'h0, 1, RST_PC, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      g = observe();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL reset[%0d]: got ce=%0b addr=%h pc=%h inst=%h, want ce=%0b addr=%h pc=%h inst=%h",
                 i, g.ce, g.addr, g.pc, g.inst, e.ce, e.addr, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_stream();
    step_t s[$];
    obs_t g, e;
    s.push_back(mk(0, 0, 0, 1, 0, 1, 32'h4, 32'h0, word_at(32'h0)));
    s.push_back(mk(0, 0, 0, 1, 0, 1, 32'h8, 32'h4, word_at(32'h4)));
    foreach (s[i]) begin
      drive(s[i]);
      g = observe();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL stream[%0d]: got ce=%0b addr=%h pc=%h inst=%h, want ce=%0b addr=%h pc=%h inst=%h",
                 i, g.ce, g.addr, g.pc, g.inst, e.ce, e.addr, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_bubble();
    step_t s[$];
    obs_t g, e;
    for (int k = 0; k < 3; k++)
      s.push_back(mk(0, 0, 0, 0, 0, 1, 32'h8, 32'h4, 32'h0));
    s.push_back(mk(0, 0, 0, 1, 0, 1, 32'hC, 32'h8, word_at(32'h8)));
    foreach (s[i]) begin
      drive(s[i]);
      g = observe();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL bubble[%0d]: got ce=%0b addr=%h pc=%h inst=%h, want ce=%0b addr=%h pc=%h inst=%h",
                 i, g.ce, g.addr, g.pc, g.inst, e.ce, e.addr, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_stall();
    step_t s[$];
    obs_t g, e;
`ifdef IF_FETCH_BUF_EN
    s.push_back(mk(0, 1, 0, 1, 0, 0, 32'h10, 32'h8, word_at(32'h8)));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 32'h10, 32'h8, word_at(32'h8)));
`else
    s.push_back(mk(0, 1, 0, 1, 0, 1, 32'hC, 32'h8, word_at(32'h8)));
    s.push_back(mk(0, 1, 0, 1, 0, 1, 32'hC, 32'h8, word_at(32'h8)));
`endif
    s.push_back(mk(0, 0, 0, 1, 0, 1, 32'h10, 32'hC, word_at(32'hC)));
    s.push_back(mk(0, 0, 0, 1, 0, 1, 32'h14, 32'h10, word_at(32'h10)));
    foreach (s[i]) begin
      drive(s[i]);
      g = observe();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL stall[%0d]: got ce=%0b addr=%h pc=%h inst=%h, want ce=%0b addr=%h pc=%h inst=%h",
                 i, g.ce, g.addr, g.pc, g.inst, e.ce, e.addr, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_flush();
    step_t s[$];
    obs_t g, e;
`ifdef IF_FETCH_BUF_EN
    s.push_back(mk(0, 1, 0, 1, 0, 0, 32'h18, 32'h10, word_at(32'h10)));
`else
    s.push_back(mk(0, 1, 0, 1, 0, 1, 32'h14, 32'h10, word_at(32'h10)));
`endif
    // Flush beats stall and drops anything buffered.
    s.push_back(mk(0, 1, 1, 1, 32'h100, 1, 32'h100, 32'h0, 32'h0));
    s.push_back(mk(0, 0, 0, 1, 0, 1, 32'h104, 32'h100, word_at(32'h100)));
    // Flush with a same-cycle ack: ack data dropped.
    s.push_back(mk(0, 0, 1, 1, 32'h100, 1, 32'h100, 32'h0, 32'h0));
    s.push_back(mk(0, 0, 0, 1, 0, 1, 32'h104, 32'h100, word_at(32'h100)));
    foreach (s[i]) begin
      drive(s[i]);
      g = observe();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL flush[%0d]: got ce=%0b addr=%h pc=%h inst=%h, want ce=%0b addr=%h pc=%h inst=%h",
                 i, g.ce, g.addr, g.pc, g.inst, e.ce, e.addr, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_wrap();
    step_t s[$];
    obs_t g, e;
    s.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0, 32'h0));
    s.push_back(mk(0, 0, 0, 1, 0, 1, 32'h0, 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC)));
    s.push_back(mk(0, 0, 0, 1, 0, 1, 32'h4, 32'h0, word_at(32'h0)));
    foreach (s[i]) begin
      drive(s[i]);
      g = observe();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL wrap[%0d]: got ce=%0b addr=%h pc=%h inst=%h, want ce=%0b addr=%h pc=%h inst=%h",
                 i, g.ce, g.addr, g.pc, g.inst, e.ce, e.addr, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    obs_t g, e;
`ifdef IF_FETCH_BUF_EN
    s.push_back(mk(0, 1, 0, 1, 0, 0, 32'h8, 32'h0, word_at(32'h0)));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 32'h8, 32'h0, word_at(32'h0)));
`else
    s.push_back(mk(0, 1, 0, 1, 0, 1, 32'h4, 32'h0, word_at(32'h0)));
    s.push_back(mk(0, 1, 0, 1, 0, 1, 32'h4, 32'h0, word_at(32'h0)));
`endif
    // Reset overrides stall, flush and ack together.
    s.push_back(mk(1, 1, 1, 1, 32'h200, 0, RST_PC, 32'h0, 32'h0));
    s.push_back(mk(0, 0, 0, 1, 0, 1, RST_PC, 32'h0, 32'h0));
    s.push_back(mk(0, 0, 0, 1, 0, 1, RST_PC + 32'h4, RST_PC, word_at(RST_PC)));
    foreach (s[i]) begin
      drive(s[i]);
      g = observe();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL reset_mid[%0d]: got ce=%0b addr=%h pc=%h inst=%h, want ce=%0b addr=%h pc=%h inst=%h",
                 i, g.ce, g.addr, g.pc, g.inst, e.ce, e.addr, e.pc, e.inst);
      end
    end
  endtask

  initial begin
    bus.stall_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.new_pc_i   = 32'h0;
    bus.imem_ack_i = 1'b0;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_bubble();
    test_stall();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
